wallace_mult_arbiter: RTL and testbench

WALLACE_MULT_ARBITER -- requirements
Module: wallace_mult_arbiter

---
 rtl/wallace_arb_pkg.sv | 15 +
 rtl/wallace_multiplier_16bit.sv | 31 +++
 rtl/wallace_rr_arbiter.sv | 54 +++++
 rtl/wallace_mult_arbiter.sv | 144 ++++++++++++++
 tb/tb_wallace_mult_arbiter.sv | 345 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/wallace_arb_pkg.sv
// Shared widths, default pipeline depth and FSM state type for the
// round-robin multiplier arbiter.
package wallace_arb_pkg;

  localparam int unsigned OP_W        = 16;
  localparam int unsigned RES_W       = 32;
  localparam int unsigned LATENCY_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } arb_state_e;

endpackage

// File: rtl/wallace_multiplier_16bit.sv
// Unsigned 16x16 multiplier with a LATENCY-deep result pipeline.
// Ports: clock; a_i, b_i operands; p_o product, valid LATENCY cycles after
// the operands are presented. The pipeline has no reset: results are
// qualified by the caller's own valid tags.
module wallace_multiplier_16bit
  import wallace_arb_pkg::*;
#(
  parameter int unsigned LATENCY = LATENCY_DEF
) (
  input  logic             clock,
  input  logic [OP_W-1:0]  a_i,
  input  logic [OP_W-1:0]  b_i,
  output logic [RES_W-1:0] p_o
);

  logic [RES_W-1:0] prod_c;
  logic [RES_W-1:0] pipe_q [LATENCY];

  assign prod_c = RES_W'(a_i) * RES_W'(b_i);

  // Product pipeline; stage 0 captures the accept-cycle product.
  always_ff @(posedge clock) begin
    pipe_q[0] <= prod_c;
    for (int unsigned i = 1; i < LATENCY; i++) begin
      pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign p_o = pipe_q[LATENCY-1];

endmodule

// File: rtl/wallace_rr_arbiter.sv
// Round-robin grant and pointer for the shared multiplier.
// Ports: clock, reset_n; en_i allows granting; req_i request vector;
// gnt_o one-hot grant; gnt_id_o granted index; accept_o any grant.
// After a grant to i the search starts at (i+1) mod NUM_REQ; otherwise the
// pointer holds.
module wallace_rr_arbiter #(
  parameter  int unsigned NUM_REQ = 4,
  localparam int unsigned ID_W    = $clog2(NUM_REQ)
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               en_i,
  input  logic [NUM_REQ-1:0] req_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [ID_W-1:0]    gnt_id_o,
  output logic               accept_o
);

  logic [ID_W-1:0] ptr_q, ptr_d;
  int unsigned     scan;
  logic [ID_W-1:0] scan_id;

  // First requester at or after the pointer, wrapping.
  always_comb begin
    gnt_o    = '0;
    gnt_id_o = '0;
    accept_o = 1'b0;
    scan     = 0;
    scan_id  = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      scan = 32'(ptr_q) + k;
      if (scan >= NUM_REQ) scan = scan - NUM_REQ;
      scan_id = ID_W'(scan);
      if (!accept_o && en_i && req_i[scan_id]) begin
        gnt_o[scan_id] = 1'b1;
        gnt_id_o       = scan_id;
        accept_o       = 1'b1;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (accept_o) begin
      ptr_d = (gnt_id_o == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id_o + ID_W'(1);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) ptr_q <= '0;
    else          ptr_q <= ptr_d;
  end

endmodule

// File: rtl/wallace_mult_arbiter.sv
// Shares one pipelined 16x16 multiplier among NUM_REQ requesters.
// Ports: clock, reset_n (async, active-low); arb_en grant enable / drain;
// req_valid/req_ready per-requester handshake (ready is combinational);
// req_a/req_b operands; rsp_valid one-hot result strobe with rsp_p/rsp_id
// on a shared bus; busy while ops are in flight or the FSM is not IDLE.
// Optional: define WALLACE_ARB_PERF_EN to add perf_ops, a saturating count
// of accepted operations.
module wallace_mult_arbiter
  import wallace_arb_pkg::*;
#(
  parameter  int unsigned NUM_REQ = 4,
  parameter  int unsigned LATENCY = LATENCY_DEF,
  localparam int unsigned ID_W    = $clog2(NUM_REQ)
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic                          arb_en,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ-1:0][OP_W-1:0]  req_a,
  input  logic [NUM_REQ-1:0][OP_W-1:0]  req_b,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [RES_W-1:0]              rsp_p,
  output logic [ID_W-1:0]               rsp_id,
  output logic                          busy
`ifdef WALLACE_ARB_PERF_EN
  ,
  output logic [31:0]                   perf_ops
`endif
);

  localparam int unsigned CNT_W = $clog2(LATENCY + 1);

  arb_state_e                   state_q, state_d;
  logic [CNT_W-1:0]             cnt_q, cnt_d;
  logic [LATENCY-1:0]           tag_vld_q, tag_vld_d;
  logic [LATENCY-1:0][ID_W-1:0] tag_id_q, tag_id_d;
  logic                         grant_en;
  logic                         accept;
  logic                         retire;
  logic [ID_W-1:0]              gnt_id;
  logic [OP_W-1:0]              op_a, op_b;
  logic [RES_W-1:0]             mult_p;

  // FSM state register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // FSM next state; re-enabling during drain resumes granting at once.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (arb_en) state_d = ST_RUN;
      ST_RUN:   if (!arb_en) state_d = ST_DRAIN;
      ST_DRAIN: begin
        if (arb_en)            state_d = ST_RUN;
        else if (cnt_q == '0)  state_d = ST_IDLE;
      end
      default:  state_d = ST_IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    grant_en = (state_q == ST_RUN);
    busy     = (state_q != ST_IDLE) || (cnt_q != '0);
  end

  wallace_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .clock    (clock),
    .reset_n  (reset_n),
    .en_i     (grant_en),
    .req_i    (req_valid),
    .gnt_o    (req_ready),
    .gnt_id_o (gnt_id),
    .accept_o (accept)
  );

  // Idle cycles feed zeros so the datapath does not toggle.
  assign op_a = accept ? req_a[gnt_id] : '0;
  assign op_b = accept ? req_b[gnt_id] : '0;

  wallace_multiplier_16bit #(.LATENCY(LATENCY)) u_mult (
    .clock (clock),
    .a_i   (op_a),
    .b_i   (op_b),
    .p_o   (mult_p)
  );

  assign retire = tag_vld_q[LATENCY-1];

  // Tag shift register mirrors the multiplier pipeline; in-flight count.
  always_comb begin
    tag_vld_d[0] = accept;
    tag_id_d[0]  = gnt_id;
    for (int unsigned i = 1; i < LATENCY; i++) begin
      tag_vld_d[i] = tag_vld_q[i-1];
      tag_id_d[i]  = tag_id_q[i-1];
    end
    cnt_d = cnt_q;
    if (accept && !retire)      cnt_d = cnt_q + CNT_W'(1);
    else if (!accept && retire) cnt_d = cnt_q - CNT_W'(1);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      tag_vld_q <= '0;
      tag_id_q  <= '0;
      cnt_q     <= '0;
    end else begin
      tag_vld_q <= tag_vld_d;
      tag_id_q  <= tag_id_d;
      cnt_q     <= cnt_d;
    end
  end

  // Result bus is qualified by the tag valid bit, held at zero otherwise.
  always_comb begin
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      rsp_valid[i] = retire && (tag_id_q[LATENCY-1] == ID_W'(i));
    end
    rsp_id = retire ? tag_id_q[LATENCY-1] : '0;
    rsp_p  = retire ? mult_p : '0;
  end

`ifdef WALLACE_ARB_PERF_EN
  logic [31:0] perf_q, perf_d;

  always_comb begin
    perf_d = perf_q;
    if (accept && (perf_q != '1)) perf_d = perf_q + 32'd1;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) perf_q <= '0;
    else          perf_q <= perf_d;
  end

  assign perf_ops = perf_q;
`endif

endmodule

// File: tb/tb_wallace_mult_arbiter.sv
// Bench for wallace_mult_arbiter: directed scenarios plus a random stream,
// with a round-robin / latency scoreboard watching every cycle.
module tb_wallace_mult_arbiter;

  localparam int NR  = 4;
  localparam int LAT = 4;
  localparam int IW  = 2;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 arb_en;
  logic [NR-1:0]        req_valid;
  logic [NR-1:0]        req_ready;
  logic [NR-1:0][15:0]  a_vec;
  logic [NR-1:0][15:0]  b_vec;
  logic [NR-1:0]        rsp_valid;
  logic [31:0]          rsp_p;
  logic [IW-1:0]        rsp_id;
  logic                 busy;
`ifdef WALLACE_ARB_PERF_EN
  logic [31:0]          perf_ops;
`endif

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  wallace_mult_arbiter #(.NUM_REQ(NR), .LATENCY(LAT)) dut (
    .clock     (clk),
    .reset_n   (rst_n),
    .arb_en    (arb_en),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (a_vec),
    .req_b     (b_vec),
    .rsp_valid (rsp_valid),
    .rsp_p     (rsp_p),
    .rsp_id    (rsp_id),
    .busy      (busy)
`ifdef WALLACE_ARB_PERF_EN
    ,
    .perf_ops  (perf_ops)
`endif
  );

  // Reference model: expected results queued with their due cycle.
  typedef struct {
    int          due;
    int          id;
    logic [31:0] p;
  } exp_t;

  exp_t          sb[$];
  int            m_ptr;
  int            m_acc;
  logic          m_run;
  int            g;
  logic [NR-1:0] exp_rdy;

  function automatic int rr_pick(input logic [NR-1:0] v, input int ptr);
    for (int k = 0; k < NR; k++) begin
      if (v[(ptr + k) % NR]) return (ptr + k) % NR;
    end
    return -1;
  endfunction

  // Model grants while arb_en was high at the previous edge.
  initial begin
    m_ptr = 0;
    m_acc = 0;
    m_run = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n !== 1'b1) begin
        sb.delete();
        m_ptr = 0;
        m_acc = 0;
        m_run = 1'b0;
        checks++;
        if ({req_ready, rsp_valid, rsp_p, rsp_id, busy} !== '0) begin
          errors++;
          $display("FAIL mon_reset_outputs got %h want 0", {req_ready, rsp_valid, rsp_p, rsp_id, busy});
        end
      end else begin
        g       = m_run ? rr_pick(req_valid, m_ptr) : -1;
        exp_rdy = (g >= 0) ? (NR'(1) << g) : '0;
        checks++;
        if (req_ready !== exp_rdy) begin
          errors++;
          $display("FAIL mon_ready cyc %0d got %b want %b", cyc, req_ready, exp_rdy);
        end
        if (g >= 0) begin
          sb.push_back('{cyc + LAT, g, 32'(a_vec[g]) * 32'(b_vec[g])});
          m_ptr = (g + 1) % NR;
          m_acc++;
        end
        if (sb.size() > 0 && sb[0].due == cyc) begin
          checks++;
          if (rsp_valid !== (NR'(1) << sb[0].id) || rsp_id !== IW'(sb[0].id) || rsp_p !== sb[0].p) begin
            errors++;
            $display("FAIL mon_rsp cyc %0d got v=%b id=%0d p=%h want v=%b id=%0d p=%h",
                     cyc, rsp_valid, rsp_id, rsp_p, NR'(1) << sb[0].id, sb[0].id, sb[0].p);
          end
          void'(sb.pop_front());
        end else begin
          checks++;
          if (rsp_valid !== '0 || rsp_id !== '0 || rsp_p !== '0) begin
            errors++;
            $display("FAIL mon_no_rsp cyc %0d got v=%b id=%0d p=%h want 0", cyc, rsp_valid, rsp_id, rsp_p);
          end
        end
        if (sb.size() > 0 || m_run) begin
          checks++;
          if (busy !== 1'b1) begin
            errors++;
            $display("FAIL mon_busy cyc %0d got %b want 1", cyc, busy);
          end
        end
        m_run = arb_en;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    arb_en    = 1'b0;
    req_valid = '1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (req_ready !== '0) begin errors++; $display("FAIL reset_ready got %b want 0", req_ready); end
    checks++; if (rsp_valid !== '0) begin errors++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); end
    checks++; if (rsp_p !== '0) begin errors++; $display("FAIL reset_rsp_p got %h want 0", rsp_p); end
    checks++; if (rsp_id !== '0) begin errors++; $display("FAIL reset_rsp_id got %0d want 0", rsp_id); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    tick();
    rst_n     = 1'b1;
    req_valid = '0;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_release_busy got %b want 0", busy); end
  endtask

  task automatic test_single();
    int acc;
    bit found;
    a_vec[0] = 16'h1234;
    b_vec[0] = 16'h5678;
    tick();
    arb_en    = 1'b1;
    req_valid = 4'b0001;
    @(negedge clk);
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL single_idle_ready got %b want 0000", req_ready); end
    tick();
    @(negedge clk);
    acc = cyc;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL single_grant got %b want 0001", req_ready); end
    tick();
    req_valid = '0;
    found = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (!found && rsp_valid !== '0) begin
        found = 1'b1;
        checks++; if (cyc - acc != LAT) begin errors++; $display("FAIL single_latency got %0d want %0d", cyc - acc, LAT); end
        checks++; if (rsp_valid !== 4'b0001) begin errors++; $display("FAIL single_rsp_valid got %b want 0001", rsp_valid); end
        checks++; if (rsp_p !== 32'h06260060) begin errors++; $display("FAIL single_rsp_p got %h want 06260060", rsp_p); end
        checks++; if (rsp_id !== 2'd0) begin errors++; $display("FAIL single_rsp_id got %0d want 0", rsp_id); end
      end
    end
    if (!found) begin
      checks++; errors++;
      $display("FAIL single_timeout got no rsp_valid want one within 10 cycles");
    end
  endtask

  task automatic test_all_rr();
    int ids[$];
    tick();
    arb_en    = 1'b0;
    req_valid = '0;
    rst_n     = 1'b0;
    tick();
    rst_n  = 1'b1;
    arb_en = 1'b1;
    for (int k = 0; k < 16; k++) begin
      tick();
      req_valid = (k < 8) ? '1 : '0;
      for (int r = 0; r < NR; r++) begin
        a_vec[r] = 16'($urandom);
        b_vec[r] = 16'($urandom);
      end
      @(negedge clk);
      if (k < 8) begin
        checks++;
        if (req_ready !== (NR'(1) << (k % NR))) begin
          errors++;
          $display("FAIL rr_grant k=%0d got %b want %b", k, req_ready, NR'(1) << (k % NR));
        end
      end
      if (rsp_valid !== '0) ids.push_back(int'(rsp_id));
    end
    checks++;
    if (ids.size() != 8) begin errors++; $display("FAIL rr_rsp_count got %0d want 8", ids.size()); end
    for (int i = 0; i < ids.size(); i++) begin
      checks++;
      if (ids[i] != i % NR) begin errors++; $display("FAIL rr_rsp_order idx %0d got %0d want %0d", i, ids[i], i % NR); end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] ps[$];
    int          cs[$];
    for (int k = 0; k < 10; k++) begin
      tick();
      req_valid = (k < 2) ? 4'b0100 : 4'b0000;
      a_vec[2]  = (k == 0) ? 16'hFFFF : 16'h8000;
      b_vec[2]  = (k == 0) ? 16'hFFFF : 16'h8000;
      @(negedge clk);
      if (k < 2) begin
        checks++;
        if (req_ready !== 4'b0100) begin errors++; $display("FAIL b2b_grant k=%0d got %b want 0100", k, req_ready); end
      end
      if (rsp_valid !== '0) begin
        ps.push_back(rsp_p);
        cs.push_back(cyc);
      end
    end
    checks++;
    if (ps.size() != 2) begin
      errors++;
      $display("FAIL b2b_count got %0d want 2", ps.size());
    end else begin
      checks++; if (ps[0] !== 32'hFFFE0001) begin errors++; $display("FAIL b2b_p0 got %h want fffe0001", ps[0]); end
      checks++; if (ps[1] !== 32'h40000000) begin errors++; $display("FAIL b2b_p1 got %h want 40000000", ps[1]); end
      checks++; if (cs[1] - cs[0] != 1) begin errors++; $display("FAIL b2b_gap got %0d want 1", cs[1] - cs[0]); end
    end
  endtask

  task automatic test_drain();
    int nrsp = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      arb_en    = (k < 2);
      req_valid = '1;
      for (int r = 0; r < NR; r++) begin
        a_vec[r] = 16'($urandom);
        b_vec[r] = 16'($urandom);
      end
      @(negedge clk);
      checks++;
      if (k < 3 && req_ready === '0) begin
        errors++; $display("FAIL drain_grant k=%0d got %b want one-hot", k, req_ready);
      end else if (k >= 3 && req_ready !== '0) begin
        errors++; $display("FAIL drain_no_grant k=%0d got %b want 0000", k, req_ready);
      end
      if (k == 3) begin
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL drain_busy got %b want 1", busy); end
      end
      if (rsp_valid !== '0) nrsp++;
    end
    checks++; if (nrsp != 3) begin errors++; $display("FAIL drain_rsp_count got %0d want 3", nrsp); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL drain_idle_busy got %b want 0", busy); end
    tick();
    req_valid = '0;
  endtask

  task automatic test_reset_mid();
    tick();
    arb_en    = 1'b1;
    req_valid = 4'b0011;
    tick();
    tick();
    tick();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rstmid_busy_before got %b want 1", busy); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (req_ready !== '0) begin errors++; $display("FAIL rstmid_ready got %b want 0", req_ready); end
    checks++; if (rsp_valid !== '0) begin errors++; $display("FAIL rstmid_rsp_valid got %b want 0", rsp_valid); end
    checks++; if (rsp_p !== '0) begin errors++; $display("FAIL rstmid_rsp_p got %h want 0", rsp_p); end
    checks++; if (rsp_id !== '0) begin errors++; $display("FAIL rstmid_rsp_id got %0d want 0", rsp_id); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %b want 0", busy); end
    tick();
    rst_n     = 1'b1;
    arb_en    = 1'b0;
    req_valid = '0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      checks++;
      if (rsp_valid !== '0) begin errors++; $display("FAIL rstmid_stale_rsp k=%0d got %b want 0", k, rsp_valid); end
      tick();
    end
  endtask

  task automatic test_random();
    bit done = 1'b0;
    for (int k = 0; k < 200 && !done; k++) begin
      tick();
      if (m_acc >= 20) begin
        req_valid = '0;
        done      = 1'b1;
      end else begin
        arb_en    = 1'b1;
        req_valid = NR'($urandom);
        for (int r = 0; r < NR; r++) begin
          a_vec[r] = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
          b_vec[r] = ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom);
        end
      end
    end
    checks++; if (m_acc != 20) begin errors++; $display("FAIL random_accepts got %0d want 20", m_acc); end
    arb_en = 1'b0;
    repeat (12) tick();
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL random_final_busy got %b want 0", busy); end
`ifdef WALLACE_ARB_PERF_EN
    checks++; if (perf_ops !== 32'd20) begin errors++; $display("FAIL perf_ops got %0d want 20", perf_ops); end
`endif
  endtask

  initial begin
    rst_n     = 1'b0;
    arb_en    = 1'b0;
    req_valid = '0;
    a_vec     = '0;
    b_vec     = '0;
    test_reset();
    test_single();
    test_all_rr();
    test_back_to_back();
    test_drain();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
